// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared opcode, ALU-control and FSM encodings for the multi-cycle RV32I core
package multicycle_controller_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALUOP_R      = 3'd0;
    localparam logic [2:0] ALUOP_I      = 3'd1;
    localparam logic [2:0] ALUOP_BRANCH = 3'd2;
    localparam logic [2:0] ALUOP_J      = 3'd3;
    localparam logic [2:0] ALUOP_MEM    = 3'd4;
    localparam logic [2:0] ALUOP_U      = 3'd5;

    localparam logic [1:0] SRC2_REG  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] SRC2_FOUR = 2'b10;

    localparam logic [1:0] SRC1_REG  = 2'b00;
    localparam logic [1:0] SRC1_ZERO = 2'b01;
    localparam logic [1:0] SRC1_PC   = 2'b10;

    localparam logic PCSRC_PC  = 1'b0;
    localparam logic PCSRC_RS1 = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef struct packed {
        logic r;
        logic i;
        logic lui;
        logic auipc;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
    } inst_class_t;

endpackage

// File: rtl/inst_class_decode.sv
// inst_class_decode: opcode -> one-hot instruction class plus legal flag (in: opcode[6:0]; out: cls, legal)
module inst_class_decode
    import multicycle_controller_pkg::*;
(
    input  logic [6:0]  opcode,
    output inst_class_t cls,
    output logic        legal
);

    always_comb begin
        cls.r      = opcode == OP_R;
        cls.i      = opcode == OP_I;
        cls.lui    = opcode == OP_LUI;
        cls.auipc  = opcode == OP_AUIPC;
        cls.load   = opcode == OP_LOAD;
        cls.store  = opcode == OP_STORE;
        cls.branch = opcode == OP_BRANCH;
        cls.jal    = opcode == OP_JAL;
        cls.jalr   = opcode == OP_JALR;
        legal      = |cls;
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV32I datapath
//   in : clk, rst_n (sync active-low), inst, zero, mem_ready
//   out: ALUSrc, ALUSrc1, PCSrc, ALUOp, funct3, funct7, ir/pc/reg/mem strobes, pc_sel, wb_sel, illegal, retired
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALUOPWIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           inst,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [1:0]            ALUSrc,
    output logic [1:0]            ALUSrc1,
    output logic                  PCSrc,
    output logic [ALUOPWIDTH-1:0] ALUOp,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  pc_sel,
    output logic                  wb_sel,
    output logic                  illegal,
    output logic [31:0]           retired
);

    state_t      state, state_nxt;
    logic [6:0]  opcode;
    inst_class_t cls;
    logic        legal;
    logic        ex, mem, wb, act;
    logic [2:0]  op;
    logic        unused_inst;

    assign unused_inst = ^{inst[24:15], inst[11:7]};

    inst_class_decode u_dec (
        .opcode (opcode),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                opcode <= inst[6:0];
                funct3 <= inst[14:12];
                funct7 <= inst[31:25];
            end
            if (state == S_DECODE && !legal)
                illegal <= 1'b1;
            // Every retiring cycle is exactly a cycle that commits the PC.
            if (pc_write)
                retired <= retired + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE:    state_nxt = legal ? S_EXECUTE : S_HALT;
            S_EXECUTE:   state_nxt = cls.branch ? S_FETCH :
                                     (cls.load || cls.store) ? S_MEM : S_WRITEBACK;
            S_MEM:       state_nxt = !mem_ready ? S_MEM : cls.store ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_FETCH;
            default:     state_nxt = state;
        endcase
    end

    always_comb begin
        ex  = rst_n && state == S_EXECUTE;
        mem = rst_n && state == S_MEM;
        wb  = rst_n && state == S_WRITEBACK;
        // ALU selects are driven in EXECUTE and held through MEM/WRITEBACK.
        act = ex || mem || wb;
        ALUSrc1 = !act ? SRC1_REG :
                  cls.lui ? SRC1_ZERO :
                  (cls.auipc || cls.jal || cls.jalr) ? SRC1_PC : SRC1_REG;
        ALUSrc  = !act ? SRC2_REG :
                  (cls.jal || cls.jalr) ? SRC2_FOUR :
                  (cls.r || cls.branch) ? SRC2_REG : SRC2_IMM;
        PCSrc   = act && cls.jalr ? PCSRC_RS1 : PCSRC_PC;
        op      = !act ? ALUOP_R :
                  cls.i ? ALUOP_I :
                  cls.branch ? ALUOP_BRANCH :
                  (cls.jal || cls.jalr) ? ALUOP_J :
                  (cls.load || cls.store) ? ALUOP_MEM :
                  (cls.lui || cls.auipc) ? ALUOP_U : ALUOP_R;
        ALUOp     = ALUOPWIDTH'(op);
        ir_write  = rst_n && state == S_FETCH;
        mem_read  = mem && cls.load;
        mem_write = mem && cls.store;
        pc_write  = (ex && cls.branch) || (mem && cls.store && mem_ready) || wb;
        reg_write = wb;
        pc_sel    = (ex && cls.branch && zero) || (wb && (cls.jal || cls.jalr));
        wb_sel    = wb && cls.load;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multi-cycle RV32I datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives the ALU's operand-select and operation inputs. It strobes the IR, PC, register-file and data-memory enables and consumes the ALU `zero` flag. It sits between instruction memory/IR and the ALU and register file, and also keeps a retired-instruction counter.

## Interface
Parameters:
- `ALUOPWIDTH`, 3: ALUOp width. Encodings R=0, I=1, BRANCH=2, J=3, MEM=4, U=5.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `inst`  in  32  instruction word from instruction memory, valid during FETCH.
- `zero`  in  1  ALU branch/condition flag.
- `mem_ready`  in  1  data memory completes the current access this cycle.
- `ALUSrc`  out  2  operand2 select: REG=00, IMM=01, FOUR=10.
- `ALUSrc1`  out  2  operand1 select: REG=00, ZERO=01, PC=10.
- `PCSrc`  out  1  target base: 0=PC (PPC), 1=rs1.
- `ALUOp`  out  ALUOPWIDTH  operation class.
- `funct3`  out  3  latched inst[14:12].
- `funct7`  out  7  latched inst[31:25].
- `ir_write`, `pc_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  enables.
- `pc_sel`  out  1  next PC: 0=PC+4, 1=ALU PCout.
- `wb_sel`  out  1  write-back data: 0=ALUResult, 1=memory data.
- `illegal`  out  1  sticky unknown-opcode flag.
- `retired`  out  32  instructions completed since reset.

## Operation
- Outputs are a Moore decode of state plus the latched opcode/funct fields. Every strobe not listed for a state is 0.
- FETCH: `ir_write`=1. Latch opcode, funct3 and funct7 from `inst`. Go to DECODE.
- DECODE: no strobes. Known opcode goes to EXECUTE. Unknown opcode sets `illegal` and goes to HALT.
- EXECUTE, by opcode:
  - R (0110011): REG/REG, ALUOp=R. Go to WRITEBACK.
  - I-ALU (0010011): ALUSrc=IMM, ALUOp=I. Go to WRITEBACK.
  - LUI (0110111): ZERO/IMM, ALUOp=U. Go to WRITEBACK.
  - AUIPC (0010111): PC/IMM, ALUOp=U. Go to WRITEBACK.
  - LOAD/STORE (0000011/0100011): REG/IMM, ALUOp=MEM. Go to MEM.
  - BRANCH (1100011): REG/REG, ALUOp=BRANCH, PCSrc=0, `pc_write`=1, `pc_sel`=`zero`. Go to FETCH; counts as retired.
  - JAL (1101111): PC/FOUR, ALUOp=J, PCSrc=0. Go to WRITEBACK with `pc_sel`=1.
  - JALR (1100111): PC/FOUR, ALUOp=J, PCSrc=1. Go to WRITEBACK with `pc_sel`=1.
- MEM: ALU selects held at their EXECUTE values. `mem_read` (load) or `mem_write` (store) held until `mem_ready`=1. On `mem_ready`:
  - Store: `pc_write`=1, `pc_sel`=0, go to FETCH, retire.
  - Load: go to WRITEBACK.
- WRITEBACK: ALU selects held. `reg_write`=1, `pc_write`=1, `wb_sel`=1 only for loads. `pc_sel`=1 for JAL/JALR, else 0. Go to FETCH, retire.
- HALT: all strobes 0. Stays in HALT until reset.
- `retired` increments by 1 on each retiring edge and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: on a clock edge with `rst_n`=0, the FSM goes to FETCH, latched fields clear to 0, `illegal`=0, `retired`=0. While `rst_n`=0, every strobe and `pc_sel`/`wb_sel` is forced to 0 combinationally, and ALUSrc/ALUSrc1/PCSrc/ALUOp are 0.
- The first FETCH `ir_write` pulse occurs in the first cycle with `rst_n`=1.
- Reset mid-MEM: the access is abandoned, with no `pc_write` or `reg_write`.
- Cycles per instruction, with W = cycles `mem_ready` is low:
  - Branch: 3.
  - R, I, LUI, AUIPC, JAL, JALR: 4.
  - Store: 4+W.
  - Load: 5+W.
- `mem_ready` is sampled only in MEM; asserting it elsewhere has no effect.
- `mem_ready`=1 on the first MEM cycle gives W=0.

## Structure
- Opcode, state, ALUOp, and ALUSrc/ALUSrc1/PCSrc encodings are defined once in the shared constants header, which is included by both the ALU and this block.
- One combinational sub-module, `inst_class_decode`: 7-bit opcode in, one-hot class plus `legal` out. The FSM and output decode remain in `multicycle_controller`.

## Test plan
- `inst`=0x002081B3 (add x3,x1,x2) → ALUOp=R and REG/REG in EXECUTE; `reg_write`=1 and `pc_write`=1 (pc_sel=0) in cycle 4; `retired`=1 afterwards.
- `inst`=0x00000463 (beq x0,x0,8) with `zero`=1 → cycle 3 `pc_write`=1, `pc_sel`=1. Repeat with `zero`=0 → `pc_sel`=0. No `reg_write` in either case.
- `inst`=0x0000A283 (lw x5,0(x1)) with `mem_ready` low for 3 MEM cycles → `mem_read` high for 4 cycles; then WRITEBACK with `wb_sel`=1 and `reg_write`=1; 8 cycles total.
- `inst`=0x0020A223 (sw x2,4(x1)) with `mem_ready`=1 immediately → `mem_write` for 1 cycle, `pc_write` in that same cycle, never `reg_write`; 4 cycles total.
- `inst`=0xFFFFFFFF → `illegal`=1 after DECODE; all strobes 0 for 20+ cycles; `rst_n` low for 1 edge → back to FETCH with `illegal`=0.
- Reset asserted during load MEM wait → no `reg_write`/`pc_write`; `retired`=0; next cycle after release shows `ir_write`=1. Preload `retired`=0xFFFFFFFF via forced state, retire one instruction → 0.
